// File: rtl/mux_share_arbiter_pkg.sv
// mux_share_arbiter_pkg: grant state encoding and mux select constants
package mux_share_arbiter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_A = 2'd1,
    ST_GRANT_B = 2'd2
  } state_t;
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;
endpackage

// File: rtl/mux_share_arbiter_rr_grant_fsm.sv
// rr_grant_fsm: round-robin grant state, burst counter and last-grant tracking
module rr_grant_fsm
  import mux_share_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic a_valid,
  input  logic b_valid,
  input  logic accept,
  output logic sel,
  output logic busy
);
  state_t state, state_n, other;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic last, last_n, hold_valid, other_valid;
  assign sel  = (state == ST_GRANT_B);
  assign busy = (state != ST_IDLE);
  always_comb begin
    hold_valid  = sel ? b_valid : a_valid;
    other_valid = sel ? a_valid : b_valid;
    other       = sel ? ST_GRANT_A : ST_GRANT_B;
    state_n     = state;
    cnt_n       = cnt;
    last_n      = last;
    if (state == ST_IDLE) begin
      if (a_valid || b_valid) begin
        // a lone requester wins outright; a tie goes to the source not served last
        last_n  = (a_valid && b_valid) ? ~last : (b_valid ? SEL_B : SEL_A);
        state_n = last_n ? ST_GRANT_B : ST_GRANT_A;
        cnt_n   = '0;
      end
    end else if (accept) begin
      if (cnt == CNT_W'(MAX_BURST - 1)) begin
        cnt_n = '0;
        if (other_valid) begin
          state_n = other;
          last_n  = ~sel;
        end
      end else begin
        cnt_n = cnt + 1'b1;
      end
    end else if (!hold_valid) begin
      state_n = other_valid ? other : ST_IDLE;
      last_n  = other_valid ? ~sel : last;
      cnt_n   = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      last  <= SEL_B;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      last  <= last_n;
    end
  end
endmodule

// File: rtl/mux_share_arbiter.sv
// mux_share_arbiter: two-source round-robin share of one registered output channel
module mux_share_arbiter
  import mux_share_arbiter_pkg::*;
#(
  parameter int DATA_W    = 2,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              sel,
  output logic              busy
);
  logic space, accept;
  assign space   = !out_valid || out_ready;
  assign a_ready = !reset && busy && (sel == SEL_A) && space;
  assign b_ready = !reset && busy && (sel == SEL_B) && space;
  assign accept  = (a_ready && a_valid) || (b_ready && b_valid);
  rr_grant_fsm #(.MAX_BURST(MAX_BURST), .CNT_W(CNT_W)) u_fsm (
    .clk(clk), .reset(reset), .a_valid(a_valid), .b_valid(b_valid),
    .accept(accept), .sel(sel), .busy(busy)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= (sel == SEL_B) ? b_data : a_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule
